// File: rtl/xorram_sched_pkg.sv
// Shared types and helpers for the XOR register RAM write scheduler.
package xorram_sched_pkg;

  localparam int XR_WIDTH      = 32;
  localparam int XR_DEPTH      = 32;
  localparam int XR_ADDR_WIDTH = $clog2(XR_DEPTH);

  typedef logic [XR_ADDR_WIDTH-1:0] addr_t;
  typedef logic [XR_WIDTH-1:0]      word_t;

  typedef struct packed {
    addr_t addr;
    word_t data;
  } wreq_t;

  typedef enum logic [0:0] {INIT = 1'b0, RUN = 1'b1} sched_state_e;

  // Requester visited at position offset of a round-robin scan starting at base.
  function automatic int rr_index(input int base, input int offset, input int n);
    return (base + offset) % n;
  endfunction

endpackage

// File: rtl/xorram_write_scheduler_fifo.sv
// Per-requester write FIFO; pointers carry an extra wrap bit to tell full from empty.
module write_req_fifo #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH-1:0] head_addr,
  output logic [WIDTH-1:0]      head_data
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [PW:0]           wr_ptr;
  logic [PW:0]           rd_ptr;
  logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
  logic [WIDTH-1:0]      mem_data [FIFO_DEPTH];

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head_addr = mem_addr[rd_ptr[PW-1:0]];
  assign head_data = mem_data[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + (PW+1)'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + (PW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_addr[wr_ptr[PW-1:0]] <= push_addr;
      mem_data[wr_ptr[PW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/xorram_write_scheduler.sv
// Shares the XOR register RAM write ports among buffered requesters, round-robin,
// after zeroing the whole RAM following every reset.
module xorram_write_scheduler
  import xorram_sched_pkg::*;
#(
  parameter int WIDTH      = XR_WIDTH,
  parameter int DEPTH      = XR_DEPTH,
  parameter int N_WRITE    = 2,
  parameter int N_REQ      = 4,
  parameter int FIFO_DEPTH = 2,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [N_REQ*WIDTH-1:0]        req_data,
  output logic [N_WRITE-1:0]            wen,
  output logic [N_WRITE*ADDR_WIDTH-1:0] waddr,
  output logic [N_WRITE*WIDTH-1:0]      wdata,
  output logic                          init_done,
  output logic                          busy
);

  localparam int RR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int GI_W = (N_WRITE > 1) ? $clog2(N_WRITE) : 1;
  localparam int CP_W = ADDR_WIDTH + 2;

  localparam logic [0:0] ST_INIT = INIT;
  localparam logic [0:0] ST_RUN  = RUN;

  logic [0:0]            state;
  logic                  run;
  logic [CP_W-1:0]       clear_ptr;
  logic [CP_W-1:0]       clear_next;
  logic [RR_W-1:0]       rr_ptr;
  logic [RR_W-1:0]       rr_next;
  logic [N_REQ-1:0]      full;
  logic [N_REQ-1:0]      empty;
  logic [N_REQ-1:0]      push;
  logic [N_REQ-1:0]      pop;
  logic [ADDR_WIDTH-1:0] head_addr [N_REQ];
  logic [WIDTH-1:0]      head_data [N_REQ];
  logic [N_WRITE-1:0]    grant_valid;
  logic [ADDR_WIDTH-1:0] grant_addr [N_WRITE];
  logic [WIDTH-1:0]      grant_data [N_WRITE];

  assign run        = (state == ST_RUN);
  assign init_done  = run;
  assign req_ready  = run ? ~full : {N_REQ{1'b0}};
  assign push       = req_valid & req_ready;
  assign busy       = !run || !(&empty);
  assign clear_next = clear_ptr + CP_W'(N_WRITE);

  for (genvar i = 0; i < N_REQ; i++) begin : g_fifo
    write_req_fifo #(
      .WIDTH      (WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push[i]),
      .push_addr (req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
      .push_data (req_data[i*WIDTH +: WIDTH]),
      .pop       (pop[i]),
      .full      (full[i]),
      .empty     (empty[i]),
      .head_addr (head_addr[i]),
      .head_data (head_data[i])
    );
  end

  // Round-robin grant scan; a head colliding with an earlier pick this cycle waits.
  always_comb begin
    int              n_pick;
    logic            clash;
    logic [RR_W-1:0] idx;
    n_pick      = 0;
    clash       = 1'b0;
    idx         = '0;
    pop         = '0;
    rr_next     = rr_ptr;
    grant_valid = '0;
    for (int k = 0; k < N_WRITE; k++) begin
      grant_addr[k] = '0;
      grant_data[k] = '0;
    end
    if (run) begin
      for (int j = 0; j < N_REQ; j++) begin
        idx   = RR_W'(rr_index(int'(rr_ptr), j, N_REQ));
        clash = 1'b0;
        for (int k = 0; k < N_WRITE; k++) begin
          clash = clash | ((k < n_pick) && (grant_addr[k] == head_addr[idx]));
        end
        if (!empty[idx] && (n_pick < N_WRITE) && !clash) begin
          grant_valid[GI_W'(n_pick)] = 1'b1;
          grant_addr[GI_W'(n_pick)]  = head_addr[idx];
          grant_data[GI_W'(n_pick)]  = head_data[idx];
          pop[idx]                   = 1'b1;
          rr_next                    = RR_W'(rr_index(int'(idx), 1, N_REQ));
          n_pick                     = n_pick + 1;
        end else begin
          rr_next = rr_next;
        end
      end
    end else begin
      rr_next = rr_ptr;
    end
  end

  // RAM port drive: clear sweep during INIT, granted heads during RUN.
  always_comb begin
    wen   = '0;
    waddr = '0;
    wdata = '0;
    for (int k = 0; k < N_WRITE; k++) begin
      if (reset) begin
        wen[k] = 1'b0;
      end else if (!run) begin
        wen[k]                             = (clear_ptr + CP_W'(k)) < CP_W'(DEPTH);
        waddr[k*ADDR_WIDTH +: ADDR_WIDTH]  = clear_ptr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(k);
      end else begin
        wen[k]                             = grant_valid[k];
        waddr[k*ADDR_WIDTH +: ADDR_WIDTH]  = grant_addr[k];
        wdata[k*WIDTH +: WIDTH]            = grant_data[k];
      end
    end
  end

  // Sweep progress, INIT->RUN transition and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_INIT;
      clear_ptr <= '0;
      rr_ptr    <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          clear_ptr <= clear_next;
          if (clear_next >= CP_W'(DEPTH)) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          rr_ptr <= rr_next;
        end
        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xorram_write_scheduler.sv
// Directed bench for xorram_write_scheduler: clear sweep, grants, collisions, back-pressure, reset.
module tb_xorram_write_scheduler;
  import xorram_sched_pkg::*;

  localparam int AW = 5;
  localparam int W  = 32;
  localparam int NW = 2;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*AW-1:0] req_addr;
  logic [NR*W-1:0] req_data;
  logic [NW-1:0]   wen;
  logic [NW*AW-1:0] waddr;
  logic [NW*W-1:0] wdata;
  logic            init_done;
  logic            busy;

  int              checks = 0;
  int              errors = 0;
  logic [W-1:0]    ram [32];
  wreq_t           exp_q [NR][$];

  xorram_write_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .wen       (wen),
    .waddr     (waddr),
    .wdata     (wdata),
    .init_done (init_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Behavioural RAM fed by the write ports, for read-back checks.
  always @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NW; k++) begin
        if (wen[k]) ram[waddr[k*AW +: AW]] <= wdata[k*W +: W];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [AW-1:0] paddr(input int k);
    return waddr[k*AW +: AW];
  endfunction

  function automatic logic [W-1:0] pdata(input int k);
    return wdata[k*W +: W];
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [W-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*W +: W]   = d;
  endtask

  task automatic chk_port(input string tag, input int k, input logic [AW-1:0] a,
                          input logic [W-1:0] d);
    chk({tag, "_addr"}, 64'(paddr(k)), 64'(a));
    chk({tag, "_data"}, 64'(pdata(k)), 64'(d));
  endtask

  task automatic chk_sweep(input string tag);
    for (int c = 0; c < 16; c++) begin
      if (c > 0) step();
      chk({tag, "_wen"}, 64'(wen), 64'h3);
      chk({tag, "_a0"}, 64'(paddr(0)), 64'(2*c));
      chk({tag, "_a1"}, 64'(paddr(1)), 64'(2*c + 1));
      chk({tag, "_data"}, 64'(wdata), 64'h0);
      chk({tag, "_ready"}, 64'(req_ready), 64'h0);
      chk({tag, "_done"}, 64'(init_done), 64'h0);
    end
  endtask

  // Each granted word carries its requester id in bits 31:28; match against that queue's head.
  task automatic monitor_grants();
    int           id;
    logic [W-1:0] d;
    wreq_t        e;
    for (int k = 0; k < NW; k++) begin
      if (wen[k]) begin
        d  = pdata(k);
        id = int'(d[31:28]);
        chk("rnd_src_known", 64'((id < NR) && (exp_q[id % NR].size() > 0)), 64'h1);
        if ((id < NR) && (exp_q[id].size() > 0)) begin
          e = exp_q[id].pop_front();
          chk("rnd_order_addr", 64'(paddr(k)), 64'(e.addr));
          chk("rnd_order_data", 64'(d), 64'(e.data));
        end
      end
    end
    if (wen == 2'b11) chk("rnd_addr_distinct", 64'(paddr(0) != paddr(1)), 64'h1);
  endtask

  initial begin
    logic [NR-1:0] acc;
    int            seq;
    logic [AW-1:0] a;
    logic [W-1:0]  d;
    wreq_t         w;

    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    acc       = '0;
    seq       = 0;

    // Reset held
    step();
    step();
    chk("rst_wen", 64'(wen), 64'h0);
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_init_done", 64'(init_done), 64'h0);

    // 1. Clear sweep
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_sweep("init");
    step();
    chk("run_init_done", 64'(init_done), 64'h1);
    chk("run_idle_wen", 64'(wen), 64'h0);
    chk("run_idle_busy", 64'(busy), 64'h0);
    chk("run_ready", 64'(req_ready), 64'hf);

    // 2. Two requesters in one cycle
    set_req(0, 5'd5, 32'hA);
    set_req(2, 5'd7, 32'hB);
    req_valid = 4'b0101;
    step();
    req_valid = '0;
    chk("t2_wen", 64'(wen), 64'h3);
    chk_port("t2_p0", 0, 5'd5, 32'hA);
    chk_port("t2_p1", 1, 5'd7, 32'hB);
    chk("t2_busy", 64'(busy), 64'h1);
    step();
    chk("t2_idle_wen", 64'(wen), 64'h0);
    chk("t2_idle_busy", 64'(busy), 64'h0);

    // rr_ptr is 3: req3 must land on port 0 ahead of req1
    set_req(1, 5'd11, 32'h11);
    set_req(3, 5'd13, 32'h13);
    req_valid = 4'b1010;
    step();
    req_valid = '0;
    chk("rr3_wen", 64'(wen), 64'h3);
    chk_port("rr3_p0", 0, 5'd13, 32'h13);
    chk_port("rr3_p1", 1, 5'd11, 32'h11);
    set_req(3, 5'd14, 32'h14);
    req_valid = 4'b1000;
    step();
    req_valid = '0;
    chk("rr2_wen", 64'(wen), 64'h1);
    chk_port("rr2_p0", 0, 5'd14, 32'h14);
    step();
    chk("rr0_idle_wen", 64'(wen), 64'h0);

    // 3. All four requesters, rr_ptr = 0
    for (int i = 0; i < NR; i++) set_req(i, AW'(20 + i), W'(32'h20 + i));
    req_valid = 4'b1111;
    step();
    req_valid = '0;
    chk("t3_c1_wen", 64'(wen), 64'h3);
    chk_port("t3_c1_p0", 0, 5'd20, 32'h20);
    chk_port("t3_c1_p1", 1, 5'd21, 32'h21);
    step();
    chk("t3_c2_wen", 64'(wen), 64'h3);
    chk_port("t3_c2_p0", 0, 5'd22, 32'h22);
    chk_port("t3_c2_p1", 1, 5'd23, 32'h23);
    step();
    chk("t3_idle_wen", 64'(wen), 64'h0);

    // Random traffic: valid held until accepted, order scoreboard per requester
    for (int cyc = 0; cyc < 100; cyc++) begin
      step();
      monitor_grants();
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] || acc[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          a = AW'($urandom_range(0, 31));
          d = {4'(i), 12'(seq), 16'h5a5a};
          seq++;
          set_req(i, a, d);
        end
        acc[i] = req_valid[i] && req_ready[i];
        if (acc[i]) begin
          w.addr = req_addr[i*AW +: AW];
          w.data = req_data[i*W +: W];
          exp_q[i].push_back(w);
        end
      end
    end
    for (int cyc = 0; cyc < 40; cyc++) begin
      step();
      req_valid = '0;
      monitor_grants();
    end
    for (int i = 0; i < NR; i++) chk("rnd_drained", 64'(exp_q[i].size()), 64'h0);
    chk("rnd_busy", 64'(busy), 64'h0);

    // 4. Same-address collision with rr_ptr = 1
    set_req(0, 5'd1, 32'h40);
    req_valid = 4'b0001;
    step();
    chk("t4_pre_wen", 64'(wen), 64'h1);
    chk_port("t4_pre_p0", 0, 5'd1, 32'h40);
    set_req(1, 5'd9, 32'h91);
    set_req(3, 5'd9, 32'h93);
    req_valid = 4'b1010;
    step();
    req_valid = '0;
    chk("t4_c1_wen", 64'(wen), 64'h1);
    chk_port("t4_c1_p0", 0, 5'd9, 32'h91);
    step();
    chk("t4_c2_wen", 64'(wen), 64'h1);
    chk_port("t4_c2_p0", 0, 5'd9, 32'h93);
    step();
    chk("t4_idle_wen", 64'(wen), 64'h0);
    chk("t4_ram9", 64'(ram[9]), 64'h93);

    // 5. Back-pressure on req0 (rr_ptr set to 1 first)
    set_req(0, 5'd2, 32'h50);
    req_valid = 4'b0001;
    step();
    chk_port("t5_pre_p0", 0, 5'd2, 32'h50);
    set_req(0, 5'd16, 32'hB0);
    set_req(1, 5'd24, 32'h61);
    set_req(2, 5'd25, 32'h62);
    set_req(3, 5'd26, 32'h63);
    req_valid = 4'b1111;
    step();
    chk("t5_b_wen", 64'(wen), 64'h3);
    chk_port("t5_b_p0", 0, 5'd24, 32'h61);
    chk_port("t5_b_p1", 1, 5'd25, 32'h62);
    chk("t5_b_ready", 64'(req_ready), 64'hf);
    set_req(0, 5'd17, 32'hB1);
    set_req(1, 5'd27, 32'h71);
    set_req(2, 5'd28, 32'h72);
    set_req(3, 5'd29, 32'h73);
    step();
    chk("t5_c_ready0", 64'(req_ready[0]), 64'h0);
    chk_port("t5_c_p0", 0, 5'd26, 32'h63);
    chk_port("t5_c_p1", 1, 5'd16, 32'hB0);
    set_req(0, 5'd18, 32'hB2);
    req_valid = 4'b0001;
    step();
    chk("t5_d_ready0", 64'(req_ready[0]), 64'h1);
    chk_port("t5_d_p0", 0, 5'd27, 32'h71);
    chk_port("t5_d_p1", 1, 5'd28, 32'h72);
    step();
    req_valid = '0;
    chk("t5_e_wen", 64'(wen), 64'h3);
    chk_port("t5_e_p0", 0, 5'd29, 32'h73);
    chk_port("t5_e_p1", 1, 5'd17, 32'hB1);
    step();
    chk("t5_f_wen", 64'(wen), 64'h1);
    chk_port("t5_f_p0", 0, 5'd18, 32'hB2);
    step();
    chk("t5_idle_wen", 64'(wen), 64'h0);

    // 6. Reset with writes pending
    for (int i = 0; i < NR; i++) set_req(i, AW'(3 + i), W'(32'hC0 + i));
    req_valid = 4'b1111;
    step();
    for (int i = 0; i < NR; i++) set_req(i, AW'(7 + i), W'(32'hD0 + i));
    step();
    req_valid = '0;
    chk("t6_pending_busy", 64'(busy), 64'h1);
    reset = 1'b1;
    #1;
    chk("t6_rst_wen", 64'(wen), 64'h0);
    chk("t6_rst_ready", 64'(req_ready), 64'h0);
    chk("t6_rst_done", 64'(init_done), 64'h0);
    step();
    step();
    chk("t6_rst_hold_wen", 64'(wen), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_sweep("t6_sweep");
    step();
    chk("t6_run_done", 64'(init_done), 64'h1);
    chk("t6_run_wen", 64'(wen), 64'h0);
    chk("t6_run_busy", 64'(busy), 64'h0);
    step();
    chk("t6_run_wen2", 64'(wen), 64'h0);
    chk("t6_ram9_cleared", 64'(ram[9]), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
